// File: rtl/lsu_axil_if.sv
// AXI-lite data-memory channel bundle between the load/store unit (master)
// and the data memory (slave). Response codes are a single error bit.
interface lsu_axil_if #(
  parameter int ADDR_W = 12
);
  logic              awvalid;
  logic              awready;
  logic [ADDR_W-1:0] awaddr;
  logic [2:0]        awprot;
  logic              wvalid;
  logic              wready;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              bvalid;
  logic              bready;
  logic              bresp;
  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic [2:0]        arprot;
  logic              rvalid;
  logic              rready;
  logic [31:0]       rdata;
  logic              rresp;

  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/lsu_axil.sv
// Load/store unit: bridges the memory stage to an AXI-lite master port.
// One transaction at a time; busy stalls the pipeline until the single-cycle
// DONE response has been presented.
// Build option: MISALIGN_TRAP_EN -- when defined, misaligned halfword/word
// accesses are rejected with rsp_err; otherwise they are silently aligned.
module lsu_axil #(
  parameter int          ADDR_W = 12,
  parameter logic [2:0]  PROT   = 3'b000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_func3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        busy,
  output logic        rsp_valid,
  output logic        rsp_we,
  output logic [4:0]  rsp_rd,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  lsu_axil_if.master  axi
);

  typedef enum logic [2:0] {
    IDLE, WRITE, WR_RESP, RD_ADDR, RD_DATA, DONE
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  func3_q, func3_d;
  logic [4:0]  rd_q, rd_d;
  logic        aw_pend_q, aw_pend_d;
  logic        w_pend_q, w_pend_d;
  logic        rsp_we_q, rsp_we_d;
  logic [4:0]  rsp_rd_q, rsp_rd_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        rsp_err_q, rsp_err_d;

  logic        req_ok;
  logic [31:0] addr_al;
  logic [31:0] rsh, ld_ext;
  logic [3:0]  st_strb;
  logic [31:0] st_data;
  logic        unused_addr;

  // Only the word address bits reach the bus.
  assign unused_addr = ^addr_q[31:ADDR_W+2];

  // Request decode: legality of funct3 and natural alignment of the address.
  always_comb begin
    addr_al = req_addr;
    case (req_func3[1:0])
      2'd1:    addr_al[0]   = 1'b0;
      2'd2:    addr_al[1:0] = 2'b00;
      default: ;
    endcase
    if (req_we) req_ok = (req_func3 <= 3'd2);
    else        req_ok = (req_func3 != 3'd3) && (req_func3 != 3'd6) && (req_func3 != 3'd7);
`ifdef MISALIGN_TRAP_EN
    if ((req_func3[1:0] == 2'd1 && req_addr[0]) ||
        (req_func3[1:0] == 2'd2 && req_addr[1:0] != 2'b00))
      req_ok = 1'b0;
`endif
  end

  // Store lane steering: replicate the datum into every lane, strobe the addressed ones.
  always_comb begin
    case (func3_q[1:0])
      2'd0: begin
        st_strb = 4'b0001 << addr_q[1:0];
        st_data = {4{wdata_q[7:0]}};
      end
      2'd1: begin
        st_strb = 4'b0011 << {addr_q[1], 1'b0};
        st_data = {2{wdata_q[15:0]}};
      end
      default: begin
        st_strb = 4'b1111;
        st_data = wdata_q;
      end
    endcase
  end

  // Load lane extraction: move the addressed byte lane to bit 0, then extend.
  always_comb begin
    rsh = axi.rdata >> {addr_q[1:0], 3'b000};
    case (func3_q)
      3'd0:    ld_ext = {{24{rsh[7]}}, rsh[7:0]};
      3'd1:    ld_ext = {{16{rsh[15]}}, rsh[15:0]};
      3'd4:    ld_ext = {24'd0, rsh[7:0]};
      3'd5:    ld_ext = {16'd0, rsh[15:0]};
      default: ld_ext = rsh;
    endcase
  end

  // Address/data channels come straight from the captured request, so they
  // cannot change while a valid is pending.
  assign axi.awaddr = addr_q[ADDR_W+1:2];
  assign axi.araddr = addr_q[ADDR_W+1:2];
  assign axi.awprot = PROT;
  assign axi.arprot = PROT;
  assign axi.wdata  = st_data;
  assign axi.wstrb  = st_strb;

  assign busy      = (state_q != IDLE);
  assign rsp_we    = rsp_we_q;
  assign rsp_rd    = rsp_rd_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

  // Next-state and handshake outputs.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    func3_d     = func3_q;
    rd_d        = rd_q;
    aw_pend_d   = aw_pend_q;
    w_pend_d    = w_pend_q;
    rsp_we_d    = rsp_we_q;
    rsp_rd_d    = rsp_rd_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    axi.awvalid = 1'b0;
    axi.wvalid  = 1'b0;
    axi.bready  = 1'b0;
    axi.arvalid = 1'b0;
    axi.rready  = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          addr_d    = addr_al;
          wdata_d   = req_wdata;
          func3_d   = req_func3;
          rd_d      = req_rd;
          aw_pend_d = 1'b1;
          w_pend_d  = 1'b1;
          if (!req_ok) begin
            // Rejected access: answer directly, no bus traffic.
            rsp_we_d   = req_we;
            rsp_rd_d   = req_we ? 5'd0 : req_rd;
            rsp_data_d = 32'd0;
            rsp_err_d  = 1'b1;
            state_d    = DONE;
          end else begin
            state_d = req_we ? WRITE : RD_ADDR;
          end
        end
      end
      WRITE: begin
        // aw and w complete independently; wait until both have handshaken.
        axi.awvalid = aw_pend_q;
        axi.wvalid  = w_pend_q;
        aw_pend_d   = aw_pend_q && !axi.awready;
        w_pend_d    = w_pend_q && !axi.wready;
        if (!aw_pend_d && !w_pend_d) state_d = WR_RESP;
      end
      WR_RESP: begin
        axi.bready = 1'b1;
        if (axi.bvalid) begin
          rsp_we_d   = 1'b1;
          rsp_rd_d   = 5'd0;
          rsp_data_d = 32'd0;
          rsp_err_d  = axi.bresp;
          state_d    = DONE;
        end
      end
      RD_ADDR: begin
        axi.arvalid = 1'b1;
        if (axi.arready) state_d = RD_DATA;
      end
      RD_DATA: begin
        axi.rready = 1'b1;
        if (axi.rvalid) begin
          rsp_we_d   = 1'b0;
          rsp_rd_d   = rd_q;
          rsp_data_d = axi.rresp ? 32'd0 : ld_ext;
          rsp_err_d  = axi.rresp;
          state_d    = DONE;
        end
      end
      DONE: begin
        rsp_valid = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and captured-request registers; reset abandons any transaction.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      func3_q    <= '0;
      rd_q       <= '0;
      aw_pend_q  <= 1'b0;
      w_pend_q   <= 1'b0;
      rsp_we_q   <= 1'b0;
      rsp_rd_q   <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      func3_q    <= func3_d;
      rd_q       <= rd_d;
      aw_pend_q  <= aw_pend_d;
      w_pend_q   <= w_pend_d;
      rsp_we_q   <= rsp_we_d;
      rsp_rd_q   <= rsp_rd_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_lsu_axil.sv
// Bench for lsu_axil: directed vector table, reset-abort sequence and
// randomized traffic checked against a byte-lane reference model.
module tb_lsu_axil;
  localparam int AW = 12;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_we;
  logic [2:0]  req_func3;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        req_ready, busy, rsp_valid, rsp_we, rsp_err;
  logic [4:0]  rsp_rd;
  logic [31:0] rsp_data;

  always #5 clk = ~clk;

  lsu_axil_if #(.ADDR_W(AW)) axi ();

  lsu_axil #(.ADDR_W(AW), .PROT(3'b000)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_func3(req_func3), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_rd(req_rd), .busy(busy), .rsp_valid(rsp_valid), .rsp_we(rsp_we),
    .rsp_rd(rsp_rd), .rsp_data(rsp_data), .rsp_err(rsp_err), .axi(axi)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          bus;
    bit          err;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] wd;
    logic [AW-1:0] waddr;
  } exp_t;

  typedef struct {
    bit          we;
    logic [2:0]  f3;
    logic [31:0] addr, wdata, rdata;
    bit          resp;
    logic [4:0]  rd;
    int          aw_d, w_d, b_d, ar_d, r_d;
    bit          early;
    exp_t        e;
  } vec_t;

  // Reference: access size from funct3, lane offset from the address,
  // replicate store bytes, extract and extend load bytes arithmetically.
  function automatic exp_t model(bit we, logic [2:0] f3, logic [31:0] addr,
                                 logic [31:0] wdata, logic [31:0] rdata, bit resp);
    exp_t e;
    logic [31:0] sz, ea, v, m;
    int off;
    e = '{default: 0};
    sz = 32'd1 << f3[1:0];
    if (we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 > 3'd5)) begin
      e.err = 1'b1;
      return e;
    end
    if (addr % sz != 0) begin
`ifdef MISALIGN_TRAP_EN
      e.err = 1'b1;
      return e;
`endif
    end
    ea = addr - (addr % sz);
    off = int'(ea % 4);
    e.bus = 1'b1;
    e.waddr = ea[AW+1:2];
    e.err = resp;
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        e.wd[8*i +: 8] = wdata[8*(i % int'(sz)) +: 8];
        e.strb[i] = (i >= off) && (i < off + int'(sz));
      end
    end else if (!resp) begin
      v = rdata >> (8 * off);
      if (sz < 4) begin
        m = (32'd1 << (8 * sz)) - 1;
        v = v & m;
        if (!f3[2] && v > (m >> 1)) v = v | ~m;
      end
      e.data = v;
    end
    return e;
  endfunction

  function automatic vec_t mk(bit we, logic [2:0] f3, logic [31:0] addr, logic [31:0] wdata,
                              logic [31:0] rdata, bit resp, logic [4:0] rd,
                              int aw_d, int w_d, int b_d, int ar_d, int r_d, bit early,
                              bit bus, bit err, logic [31:0] data, logic [3:0] strb,
                              logic [31:0] wd, logic [AW-1:0] waddr);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
    v.resp = resp; v.rd = rd; v.aw_d = aw_d; v.w_d = w_d; v.b_d = b_d;
    v.ar_d = ar_d; v.r_d = r_d; v.early = early;
    v.e.bus = bus; v.e.err = err; v.e.data = data; v.e.strb = strb;
    v.e.wd = wd; v.e.waddr = waddr;
    return v;
  endfunction

  task automatic clear_slave();
    axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.bresp = 0;
    axi.arready = 0; axi.rvalid = 0; axi.rdata = 0; axi.rresp = 0;
  endtask

  // Issue one request and act as a slave with the given ready/valid delays.
  task automatic run_op(input vec_t v, input string tag);
    int cyc, aw_c, w_c, ar_c, b_c, r_c, aw_hs, ar_hs, rsp_cyc;
    bit got, aw_seen, w_seen, ar_seen, aw_pend, w_pend, ar_pend, aw_done, w_done, ar_done;
    logic [AW-1:0] aw_a, ar_a;
    logic [3:0]  st;
    logic [31:0] wd;
    cyc = 0; aw_c = 0; w_c = 0; ar_c = 0; b_c = 0; r_c = 0; aw_hs = 0; ar_hs = 0; rsp_cyc = 0;
    got = 0; aw_seen = 0; w_seen = 0; ar_seen = 0; aw_pend = 0; w_pend = 0; ar_pend = 0;
    aw_done = 0; w_done = 0; ar_done = 0; aw_a = '0; ar_a = '0; st = '0; wd = '0;
    @(negedge clk);
    req_valid = 1; req_we = v.we; req_func3 = v.f3; req_addr = v.addr;
    req_wdata = v.wdata; req_rd = v.rd;
    axi.bresp = v.resp; axi.rresp = v.resp; axi.rdata = v.rdata;
    axi.bvalid = v.early & v.we;
    axi.rvalid = v.early & ~v.we;
    chk({tag, "/req_ready"}, req_ready, 1);
    @(negedge clk);
    req_valid = 0;
    cyc = 1;
    while (!got && cyc < 60) begin
      if (rsp_valid) begin
        got = 1; rsp_cyc = cyc;
        chk({tag, "/rsp_err"}, rsp_err, v.e.err);
        chk({tag, "/rsp_we"}, rsp_we, v.we);
        chk({tag, "/rsp_data"}, rsp_data, v.e.data);
        if (!v.we) chk({tag, "/rsp_rd"}, rsp_rd, v.rd);
      end else begin
        chk({tag, "/busy"}, busy, 1);
      end
      if (axi.bready) chk({tag, "/bready_order"}, aw_done & w_done, 1);
      // write address channel
      if (aw_pend) chk({tag, "/awvalid_hold"}, axi.awvalid, 1);
      if (aw_done) chk({tag, "/awvalid_drop"}, axi.awvalid, 0);
      if (axi.awvalid) begin
        if (!aw_seen) begin aw_seen = 1; aw_a = axi.awaddr; end
        chk({tag, "/awaddr_stable"}, axi.awaddr, aw_a);
      end
      axi.awready = axi.awvalid && (aw_c >= v.aw_d);
      if (axi.awvalid) aw_c++;
      if (axi.awvalid && axi.awready) begin aw_done = 1; aw_pend = 0; aw_hs++; end
      else if (axi.awvalid) aw_pend = 1;
      // write data channel
      if (w_pend) chk({tag, "/wvalid_hold"}, axi.wvalid, 1);
      if (w_done) chk({tag, "/wvalid_drop"}, axi.wvalid, 0);
      if (axi.wvalid) begin
        if (!w_seen) begin w_seen = 1; st = axi.wstrb; wd = axi.wdata; end
        chk({tag, "/w_stable"}, {axi.wstrb, axi.wdata[27:0]}, {st, wd[27:0]});
      end
      axi.wready = axi.wvalid && (w_c >= v.w_d);
      if (axi.wvalid) w_c++;
      if (axi.wvalid && axi.wready) begin w_done = 1; w_pend = 0; end
      else if (axi.wvalid) w_pend = 1;
      // read address channel
      if (ar_pend) chk({tag, "/arvalid_hold"}, axi.arvalid, 1);
      if (ar_done) chk({tag, "/arvalid_drop"}, axi.arvalid, 0);
      if (axi.arvalid) begin
        if (!ar_seen) begin ar_seen = 1; ar_a = axi.araddr; end
        chk({tag, "/araddr_stable"}, axi.araddr, ar_a);
      end
      axi.arready = axi.arvalid && (ar_c >= v.ar_d);
      if (axi.arvalid) ar_c++;
      if (axi.arvalid && axi.arready) begin ar_done = 1; ar_pend = 0; ar_hs++; end
      else if (axi.arvalid) ar_pend = 1;
      // responses
      axi.bvalid = v.we && (v.early || (axi.bready && b_c >= v.b_d));
      if (axi.bready) b_c++;
      axi.rvalid = !v.we && (v.early || (axi.rready && r_c >= v.r_d));
      if (axi.rready) r_c++;
      @(negedge clk);
      cyc++;
    end
    if (!got) begin
      chk({tag, "/timeout"}, 0, 1);
    end else begin
      chk({tag, "/rsp_pulse"}, rsp_valid, 0);
      chk({tag, "/idle_ready"}, req_ready, 1);
      chk({tag, "/idle_busy"}, busy, 0);
      chk({tag, "/rsp_hold"}, rsp_data, v.e.data);
      if (!v.e.bus) chk({tag, "/latency"}, rsp_cyc, 1);
      else if (v.aw_d == 0 && v.w_d == 0 && v.b_d == 0 && v.ar_d == 0 && v.r_d == 0)
        chk({tag, "/latency"}, rsp_cyc, 3);
    end
    chk({tag, "/aw_count"}, aw_hs, (v.e.bus && v.we) ? 1 : 0);
    chk({tag, "/ar_count"}, ar_hs, (v.e.bus && !v.we) ? 1 : 0);
    chk({tag, "/aw_seen"}, aw_seen, v.e.bus && v.we);
    chk({tag, "/ar_seen"}, ar_seen, v.e.bus && !v.we);
    if (v.e.bus && v.we) begin
      chk({tag, "/awaddr"}, aw_a, v.e.waddr);
      chk({tag, "/wstrb"}, st, v.e.strb);
      chk({tag, "/wdata"}, wd, v.e.wd);
    end
    if (v.e.bus && !v.we) chk({tag, "/araddr"}, ar_a, v.e.waddr);
    clear_slave();
  endtask

  logic [2:0] ld_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

  initial begin
    vec_t tbl[$];
    vec_t rv;
    reset = 1; req_valid = 0; req_we = 0; req_func3 = 0; req_addr = 0;
    req_wdata = 0; req_rd = 0;
    clear_slave();
    repeat (3) @(negedge clk);
    reset = 0;
    @(negedge clk);
    chk("rst/req_ready", req_ready, 1);
    chk("rst/busy", busy, 0);
    chk("rst/valids", {axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready}, 0);
    chk("rst/rsp_valid", rsp_valid, 0);
    chk("rst/rsp", {rsp_we, rsp_err, rsp_rd}, 0);
    chk("rst/rsp_data", rsp_data, 0);
    chk("rst/prot", {axi.awprot, axi.arprot}, 0);

    //                we f3    addr          wdata         rdata         rs rd  aw w b ar r  e  bus err data          strb     wd            waddr
    tbl.push_back(mk(1, 3'd0, 32'h0000_0007, 32'h0000_00A5, 32'h0,        0, 0,  0, 0,0,0, 0, 0, 1, 0, 32'h0,        4'b1000, 32'hA5A5A5A5, 12'h001));
    tbl.push_back(mk(0, 3'd0, 32'h0000_0006, 32'h0,        32'h0080_0000, 0, 5,  0, 0,0,0, 0, 0, 1, 0, 32'hFFFFFF80, 4'b0,    32'h0,        12'h001));
    tbl.push_back(mk(0, 3'd4, 32'h0000_0006, 32'h0,        32'h0080_0000, 0, 9,  0, 0,0,0, 0, 0, 1, 0, 32'h00000080, 4'b0,    32'h0,        12'h001));
    tbl.push_back(mk(1, 3'd2, 32'h0000_0010, 32'h12345678, 32'h0,        0, 0,  3, 0,0,0, 0, 0, 1, 0, 32'h0,        4'b1111, 32'h12345678, 12'h004));
    tbl.push_back(mk(0, 3'd2, 32'h0000_0020, 32'h0,        32'hDEADBEEF, 1, 7,  0, 0,0,0, 0, 0, 1, 1, 32'h0,        4'b0,    32'h0,        12'h008));
    tbl.push_back(mk(0, 3'd3, 32'h0000_0000, 32'h0,        32'h0,        0, 4,  0, 0,0,0, 0, 0, 0, 1, 32'h0,        4'b0,    32'h0,        12'h000));
`ifdef MISALIGN_TRAP_EN
    tbl.push_back(mk(0, 3'd1, 32'h0000_0003, 32'h0,        32'hBEEF0000, 0, 3,  0, 0,0,0, 0, 0, 0, 1, 32'h0,        4'b0,    32'h0,        12'h000));
`else
    tbl.push_back(mk(0, 3'd1, 32'h0000_0003, 32'h0,        32'hBEEF0000, 0, 3,  0, 0,0,0, 0, 0, 1, 0, 32'hFFFFBEEF, 4'b0,    32'h0,        12'h000));
`endif
    tbl.push_back(mk(1, 3'd1, 32'h0000_0102, 32'h0000CAFE, 32'h0,        0, 0,  0, 0,0,0, 0, 0, 1, 0, 32'h0,        4'b1100, 32'hCAFECAFE, 12'h040));
    tbl.push_back(mk(1, 3'd3, 32'h0000_0040, 32'h11223344, 32'h0,        0, 0,  0, 0,0,0, 0, 0, 0, 1, 32'h0,        4'b0,    32'h0,        12'h000));
    tbl.push_back(mk(0, 3'd5, 32'h0000_1002, 32'h0,        32'h80011234, 0, 11, 0, 0,0,0, 0, 0, 1, 0, 32'h00008001, 4'b0,    32'h0,        12'h400));
    tbl.push_back(mk(1, 3'd2, 32'h0000_0000, 32'h0,        32'h0,        1, 0,  0, 2,2,0, 0, 0, 1, 1, 32'h0,        4'b1111, 32'h0,        12'h000));
    tbl.push_back(mk(0, 3'd2, 32'h0000_07FC, 32'h0,        32'h0BADF00D, 0, 31, 0, 0,0,2, 1, 1, 1, 0, 32'h0BADF00D, 4'b0,    32'h0,        12'h1FF));
`ifdef MISALIGN_TRAP_EN
    tbl.push_back(mk(1, 3'd1, 32'h0000_0005, 32'h1111ABCD, 32'h0,        0, 0,  0, 0,0,0, 0, 0, 0, 1, 32'h0,        4'b0,    32'h0,        12'h000));
    tbl.push_back(mk(1, 3'd2, 32'h0000_0013, 32'h55AA00FF, 32'h0,        0, 0,  0, 0,0,0, 0, 1, 0, 1, 32'h0,        4'b0,    32'h0,        12'h000));
`else
    tbl.push_back(mk(1, 3'd1, 32'h0000_0005, 32'h1111ABCD, 32'h0,        0, 0,  0, 0,0,0, 0, 0, 1, 0, 32'h0,        4'b0011, 32'hABCDABCD, 12'h001));
    tbl.push_back(mk(1, 3'd2, 32'h0000_0013, 32'h55AA00FF, 32'h0,        0, 0,  0, 0,0,0, 0, 1, 1, 0, 32'h0,        4'b1111, 32'h55AA00FF, 12'h004));
`endif
    tbl.push_back(mk(0, 3'd0, 32'h0000_1003, 32'h0,        32'h7F000000, 0, 2,  0, 0,0,0, 0, 0, 1, 0, 32'h0000007F, 4'b0,    32'h0,        12'h400));
    tbl.push_back(mk(0, 3'd1, 32'h0000_0002, 32'h0,        32'h7FFF0000, 0, 6,  0, 0,0,1, 2, 0, 1, 0, 32'h00007FFF, 4'b0,    32'h0,        12'h000));

    foreach (tbl[i]) run_op(tbl[i], $sformatf("vec%0d", i));

    // Reset while waiting for read data: everything drops, no response pulse.
    @(negedge clk);
    req_valid = 1; req_we = 0; req_func3 = 3'd2; req_addr = 32'h40; req_rd = 5'd8;
    @(negedge clk);
    req_valid = 0;
    chk("abort/arvalid", axi.arvalid, 1);
    axi.arready = 1;
    @(negedge clk);
    axi.arready = 0;
    chk("abort/rready", axi.rready, 1);
    reset = 1;
    @(negedge clk);
    chk("abort/rready_drop", axi.rready, 0);
    chk("abort/req_ready", req_ready, 1);
    chk("abort/busy", busy, 0);
    chk("abort/rsp_valid", rsp_valid, 0);
    reset = 0;
    axi.rvalid = 1; axi.rdata = 32'h12345678;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort/no_rsp", rsp_valid, 0);
    end
    clear_slave();

    // Randomized traffic against the reference model.
    for (int n = 0; n < 60; n++) begin
      rv.we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) rv.f3 = 3'($urandom_range(0, 7));
      else if (rv.we) rv.f3 = 3'($urandom_range(0, 2));
      else rv.f3 = ld_f3[$urandom_range(0, 4)];
      rv.addr = $urandom; rv.wdata = $urandom; rv.rdata = $urandom;
      rv.resp = ($urandom_range(0, 3) == 0);
      rv.rd = 5'($urandom_range(0, 31));
      rv.aw_d = $urandom_range(0, 3); rv.w_d = $urandom_range(0, 3);
      rv.b_d = $urandom_range(0, 3); rv.ar_d = $urandom_range(0, 3);
      rv.r_d = $urandom_range(0, 3); rv.early = ($urandom_range(0, 3) == 0);
      rv.e = model(rv.we, rv.f3, rv.addr, rv.wdata, rv.rdata, rv.resp);
      run_op(rv, $sformatf("rnd%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
